pconv_accum: RTL and testbench

Receiving end of the partial-convolution datapath. Accepts a stream of 18-bit signed partial sums, each the sum of three data×weight products with 7 fractional bits. Accumulates `NUM_PASS` consecutive partials into one output pixel, adds a per-pixel bias, then applies ReLU, rounding and saturation. Emits an 8-bit unsigned pixel over a valid/ready handshake with full throughput and backpressure.

---
 rtl/pconv_pkg.sv | 22 ++
 rtl/pix_requant.sv | 39 +++
 rtl/pconv_accum.sv | 140 ++++++++++++++
 tb/tb_pconv_accum.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pconv_pkg.sv
// ---------------------------------------------------------------------------
// pconv_pkg
// Shared constants and types for the partial-convolution receive datapath.
//   PCONV_LEN   : width of one signed partial sum
//   FRAC_BITS   : fractional bits carried by the partial sums
//   OUT_LEN     : width of the unsigned output pixel
//   ROUND_CONST : half of one output LSB, added before truncation
//   pass_state_e: accumulation phase of the current pixel
// ---------------------------------------------------------------------------
package pconv_pkg;

  localparam int PCONV_LEN   = 32'sd18;
  localparam int FRAC_BITS   = 32'sd7;
  localparam int OUT_LEN     = 32'sd8;
  localparam int ROUND_CONST = 32'sd1 << (FRAC_BITS - 32'sd1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } pass_state_e;

endpackage : pconv_pkg

// File: rtl/pix_requant.sv
// ---------------------------------------------------------------------------
// pix_requant
// Combinational ReLU, round-half-up and saturate of a signed fixed-point sum
// down to an unsigned integer pixel.
//   acc_sum : signed sum with FRAC_BITS fractional bits (ACC_LEN wide)
//   pix     : unsigned pixel (OUT_LEN wide), clamped to 0..2^OUT_LEN-1
// ---------------------------------------------------------------------------
module pix_requant
  import pconv_pkg::*;
#(
  parameter int ACC_LEN = 22,
  parameter int FRAC_W  = FRAC_BITS,
  parameter int OUT_W   = OUT_LEN
) (
  input  logic signed [ACC_LEN-1:0] acc_sum,
  output logic        [OUT_W-1:0]   pix
);

  // One extra bit so adding the rounding constant to a large positive sum
  // cannot wrap.
  localparam logic [ACC_LEN:0] RND = (ACC_LEN+1)'(ROUND_CONST);

  logic [ACC_LEN:0]        rounded_s;
  logic [ACC_LEN-FRAC_W:0] shifted_s;

  // ReLU, round and clamp the sum into the output range
  always_comb begin
    rounded_s = {1'b0, acc_sum} + RND;
    shifted_s = rounded_s[ACC_LEN:FRAC_W];
    if (acc_sum[ACC_LEN-1]) begin
      pix = '0;
    end else if (|shifted_s[ACC_LEN-FRAC_W:OUT_W]) begin
      pix = '1;
    end else begin
      pix = shifted_s[OUT_W-1:0];
    end
  end

endmodule : pix_requant

// File: rtl/pconv_accum.sv
// ---------------------------------------------------------------------------
// pconv_accum
// Accumulates NUM_PASS signed partial sums per pixel, adds a per-pixel bias
// (taken with the first partial), requantizes and emits one unsigned pixel
// over valid/ready. Non-final partials of the next pixel keep flowing while
// an output pixel is still waiting for the consumer.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_pconv_valid/o_pconv_ready, i_pconv, i_bias : partial-sum input channel
//   i_flush                 : synchronous abort of pixel in progress + output
//   o_pix_valid/i_pix_ready, o_pix : pixel output channel
//   o_busy                  : a pixel is in progress or an output is pending
// ---------------------------------------------------------------------------
module pconv_accum
  import pconv_pkg::*;
#(
  parameter int PCONV_LEN = pconv_pkg::PCONV_LEN,
  parameter int NUM_PASS  = 3,
  parameter int ACC_LEN   = 22,
  parameter int FRAC_BITS = pconv_pkg::FRAC_BITS,
  parameter int OUT_LEN   = pconv_pkg::OUT_LEN
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_pconv_valid,
  output logic                        o_pconv_ready,
  input  logic signed [PCONV_LEN-1:0] i_pconv,
  input  logic signed [7:0]           i_bias,
  input  logic                        i_flush,
  output logic                        o_pix_valid,
  input  logic                        i_pix_ready,
  output logic        [OUT_LEN-1:0]   o_pix,
  output logic                        o_busy
);

  localparam int CNT_W = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PASS - 1);

  logic [CNT_W-1:0]          cnt_r,       cnt_nxt_s;
  logic signed [ACC_LEN-1:0] acc_r,       acc_nxt_s;
  logic [OUT_LEN-1:0]        pix_r,       pix_nxt_s;
  logic                      pix_valid_r, pix_valid_nxt_s;
  logic                      busy_r;
  pass_state_e               state_s;
  logic                      last_s;
  logic                      ready_s;
  logic                      accept_s;
  logic signed [ACC_LEN-1:0] pconv_ext_s;
  logic signed [ACC_LEN-1:0] bias_ext_s;
  logic signed [ACC_LEN-1:0] acc_sum_s;
  logic [OUT_LEN-1:0]        requant_s;

  // Decode the pass phase and the input-side handshake
  always_comb begin
    state_s  = (cnt_r == '0) ? S_IDLE : S_ACC;
    last_s   = (cnt_r == LAST_CNT);
    // Only the final partial needs the output register to be free.
    ready_s  = ~last_s | ~pix_valid_r | i_pix_ready;
    accept_s = i_pconv_valid & ready_s & ~i_flush;
  end

  // Sign-extend the partial and align the integer bias to the fraction point
  always_comb begin
    pconv_ext_s = {{(ACC_LEN-PCONV_LEN){i_pconv[PCONV_LEN-1]}}, i_pconv};
    bias_ext_s  = {{(ACC_LEN-8-FRAC_BITS){i_bias[7]}}, i_bias, {FRAC_BITS{1'b0}}};
  end

  // First partial of a pixel restarts the sum from the bias; later ones add
  always_comb begin
    case (state_s)
      S_IDLE:  acc_sum_s = pconv_ext_s + bias_ext_s;
      S_ACC:   acc_sum_s = acc_r + pconv_ext_s;
      default: acc_sum_s = pconv_ext_s + bias_ext_s;
    endcase
  end

  pix_requant #(
    .ACC_LEN (ACC_LEN),
    .FRAC_W  (FRAC_BITS),
    .OUT_W   (OUT_LEN)
  ) u_requant (
    .acc_sum (acc_sum_s),
    .pix     (requant_s)
  );

  // Next-state for counter, accumulator and output register
  always_comb begin
    cnt_nxt_s       = cnt_r;
    acc_nxt_s       = acc_r;
    pix_nxt_s       = pix_r;
    pix_valid_nxt_s = pix_valid_r;
    if (i_flush) begin
      cnt_nxt_s       = '0;
      acc_nxt_s       = '0;
      pix_valid_nxt_s = 1'b0;
    end else begin
      if (accept_s) begin
        acc_nxt_s = acc_sum_s;
        if (last_s) begin
          cnt_nxt_s = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
      // A new pixel completing in the handoff cycle keeps valid high.
      if (accept_s && last_s) begin
        pix_nxt_s       = requant_s;
        pix_valid_nxt_s = 1'b1;
      end else if (i_pix_ready) begin
        pix_valid_nxt_s = 1'b0;
      end else begin
        pix_valid_nxt_s = pix_valid_r;
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r       <= '0;
      acc_r       <= '0;
      pix_r       <= '0;
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      pix_r       <= pix_nxt_s;
      pix_valid_r <= pix_valid_nxt_s;
      busy_r      <= (cnt_nxt_s != '0) | pix_valid_nxt_s;
    end
  end

  assign o_pconv_ready = ready_s;
  assign o_pix_valid   = pix_valid_r;
  assign o_pix         = pix_r;
  assign o_busy        = busy_r;

endmodule : pconv_accum

// File: tb/tb_pconv_accum.sv
// ---------------------------------------------------------------------------
// tb_pconv_accum
// Self-checking bench for pconv_accum: directed scenarios with hand-computed
// pixels, then randomized traffic checked every cycle against a queue-based
// reference model of the pixel arithmetic and handshake.
// ---------------------------------------------------------------------------
module tb_pconv_accum;

  localparam int NP = 3;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_pconv_valid = 1'b0;
  logic               o_pconv_ready;
  logic signed [17:0] i_pconv = '0;
  logic signed [7:0]  i_bias = '0;
  logic               i_flush = 1'b0;
  logic               o_pix_valid;
  logic               i_pix_ready = 1'b0;
  logic [7:0]         o_pix;
  logic               o_busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int cur_q[$];
  int cur_bias = 0;
  bit m_pend = 1'b0;
  int m_pix = 0;

  always #5 i_clk = ~i_clk;

  pconv_accum #(
    .PCONV_LEN (18),
    .NUM_PASS  (NP),
    .ACC_LEN   (22),
    .FRAC_BITS (7),
    .OUT_LEN   (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pconv_valid (i_pconv_valid),
    .o_pconv_ready (o_pconv_ready),
    .i_pconv       (i_pconv),
    .i_bias        (i_bias),
    .i_flush       (i_flush),
    .o_pix_valid   (o_pix_valid),
    .i_pix_ready   (i_pix_ready),
    .o_pix         (o_pix),
    .o_busy        (o_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ReLU, round half up, clamp -- plain integer arithmetic
  function automatic int requant_ref(input int s);
    int r;
    if (s < 0) return 0;
    r = (s + 64) / 128;
    return (r > 255) ? 255 : r;
  endfunction

  // Compare DUT against the model, then advance the model to the next edge
  always @(negedge i_clk) begin
    int exp_ready;
    int s;
    if (!i_rst_n) begin
      cur_q.delete();
      m_pend = 1'b0;
      m_pix  = 0;
      chk("rst_valid", int'(o_pix_valid), 0);
      chk("rst_pix",   int'(o_pix), 0);
      chk("rst_busy",  int'(o_busy), 0);
      chk("rst_ready", int'(o_pconv_ready), 1);
    end else begin
      exp_ready = (cur_q.size() == NP-1 && m_pend && !i_pix_ready) ? 0 : 1;
      chk("m_valid", int'(o_pix_valid), int'(m_pend));
      chk("m_pix",   int'(o_pix), m_pix);
      chk("m_ready", int'(o_pconv_ready), exp_ready);
      chk("m_busy",  int'(o_busy), (cur_q.size() != 0 || m_pend) ? 1 : 0);
      if (i_flush) begin
        cur_q.delete();
        m_pend = 1'b0;
      end else begin
        if (m_pend && i_pix_ready) m_pend = 1'b0;
        if (i_pconv_valid && exp_ready == 1) begin
          if (cur_q.size() == 0) cur_bias = int'(i_bias);
          cur_q.push_back(int'(i_pconv));
          if (cur_q.size() == NP) begin
            s = cur_bias * 128;
            foreach (cur_q[k]) s += cur_q[k];
            m_pix  = requant_ref(s);
            m_pend = 1'b1;
            cur_q.delete();
          end
        end
      end
    end
  end

  // Offer one partial and hold it until the accepting edge has passed
  task automatic send(input int p, input int b);
    bit took;
    i_pconv_valid = 1'b1;
    i_pconv       = 18'(p);
    i_bias        = 8'(b);
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      took = o_pconv_ready && !i_flush;
      @(posedge i_clk);
      #1;
      if (took) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    i_pconv_valid = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  // One full pixel, then check the value one cycle after the last accept
  task automatic run_pixel(input int p0, input int p1, input int p2,
                           input int b, input int exp_pix, input string name);
    send(p0, b);
    send(p1, b);
    send(p2, b);
    i_pconv_valid = 1'b0;
    @(negedge i_clk);
    chk({name, "_valid"}, int'(o_pix_valid), 1);
    chk(name, int'(o_pix), exp_pix);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // pin the reference arithmetic itself
    chk("ref_round_up",  requant_ref(64), 1);
    chk("ref_round_dn",  requant_ref(63), 0);
    chk("ref_relu",      requant_ref(-1000 + 384), 0);
    chk("ref_sat",       requant_ref(97155 * 3), 255);

    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle_cycle();

    // basic pixel and latency
    i_pix_ready = 1'b1;
    run_pixel(128, 128, 128, 0, 3, "basic");
    run_pixel(64, 0, 0, 0, 1, "round_half");
    run_pixel(63, 0, 0, 0, 0, "round_below");
    run_pixel(-1000, 0, 0, 3, 0, "relu");
    run_pixel(97155, 97155, 97155, 0, 255, "saturate");
    idle_cycle();
    @(negedge i_clk);
    chk("drained_valid", int'(o_pix_valid), 0);
    @(posedge i_clk);
    #1;

    // backpressure: pixel 1 = 768/128 = 6, pixel 2 = 640/128 = 5
    i_pix_ready = 1'b0;
    send(128, 0); send(256, 0); send(384, 0);
    send(640, 0); send(0, 0);
    i_pconv_valid = 1'b1;
    i_pconv = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      chk("bp_stall_ready", int'(o_pconv_ready), 0);
      chk("bp_hold_valid",  int'(o_pix_valid), 1);
      chk("bp_hold_pix",    int'(o_pix), 6);
      @(posedge i_clk);
      #1;
    end
    i_pix_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_release_ready", int'(o_pconv_ready), 1);
    @(posedge i_clk);
    #1;
    i_pconv_valid = 1'b0;
    @(negedge i_clk);
    chk("bp_p2_valid", int'(o_pix_valid), 1);
    chk("bp_p2_pix",   int'(o_pix), 5);
    @(posedge i_clk);
    #1;
    idle_cycle();

    // flush discards partial pixel: (30 + 128 + 64) >> 7 = 1
    send(500, 7); send(500, 7);
    i_pconv_valid = 1'b0;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_busy", int'(o_busy), 0);
    @(posedge i_clk);
    #1;
    run_pixel(10, 10, 10, 1, 1, "after_flush");

    // flush also drops a pending output
    i_pix_ready = 1'b0;
    send(128, 0); send(128, 0); send(128, 0);
    i_pconv_valid = 1'b0;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_pending", int'(o_pix_valid), 0);
    @(posedge i_clk);
    #1;

    // asynchronous reset mid-pixel with an output pending
    send(128, 0); send(128, 0); send(128, 0);
    send(128, 0);
    i_pconv_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_pix_valid), 0);
    chk("arst_pix",   int'(o_pix), 0);
    chk("arst_busy",  int'(o_busy), 0);
    chk("arst_ready", int'(o_pconv_ready), 1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_pix_ready = 1'b1;
    run_pixel(256, 0, 0, 0, 2, "after_reset");

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      int v;
      v = int'($urandom_range(0, 20000)) - 8000;
      i_pconv_valid = ($urandom_range(0, 3) != 0);
      i_pconv       = 18'(v);
      i_bias        = 8'($urandom_range(0, 255));
      i_pix_ready   = ($urandom_range(0, 3) != 0);
      i_flush       = ($urandom_range(0, 63) == 0);
      @(posedge i_clk);
      #1;
    end
    i_pconv_valid = 1'b0;
    i_flush = 1'b0;
    i_pix_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pconv_accum
